pc_if_stage: RTL and testbench
==============================

PC_IF_STAGE -- requirements
Module: pc_if_stage

Interface
REQ-001 The block SHALL take parameter NBITS, default 32, as the address and instruction width.
REQ-002 The block SHALL take parameter HALT_WORD, default 32'hFFFFFFFF, as the instruction encoding that stops fetch.
REQ-003 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 i_rst_n  input  1  synchronous, active-low reset.
REQ-005 i_Enable  input  1  debug-unit run/step enable; 0 freezes all state.
REQ-006 i_Stall  input  1  hazard-unit stall; holds PC and IF/ID.
REQ-007 i_Flush  input  1  branch taken in ID; squashes the IF/ID contents.
REQ-008 i_MuxPC  input  NBITS  next-PC value from the PC mux.
REQ-009 i_Instruccion  input  NBITS  instruction-memory read data for o_PC, combinational and same cycle.
REQ-010 o_PC  output  NBITS  current PC, driving the instruction-memory address.
REQ-011 o_PC4  output  NBITS  o_PC+4, combinational, feeding the PC+4 mux input.
REQ-012 o_IFID_Instr  output  NBITS  registered instruction.
REQ-013 o_IFID_PC4  output  NBITS  registered PC+4 of that instruction.
REQ-014 o_IFID_Valid  output  1  1 = o_IFID_Instr is a real fetched instruction.
REQ-015 o_Halt  output  1  1 while the FSM is in HALT.
REQ-016 o_CycleCount  output  32  number of enabled cycles spent in RUN.

Function
REQ-017 The FSM SHALL have exactly two states: RUN and HALT.
REQ-018 The block SHALL ignore i_Stall, i_Flush and i_Instruccion while i_Enable=0, and hold every register.
REQ-019 In RUN with i_Enable=1, the PC SHALL load i_MuxPC when i_Flush=1 or i_Stall=0; otherwise it holds.
REQ-020 With i_Enable=1 and i_Flush=1, IF/ID SHALL load Instr=NOP (all zeros), PC4=0 and Valid=0 in any state; flush has priority over both stall and halt.
REQ-021 In RUN with i_Enable=1, i_Flush=0 and i_Stall=0, IF/ID SHALL load Instr=i_Instruccion, PC4=o_PC4 and Valid=1.
REQ-022 In RUN with i_Enable=1, i_Flush=0 and i_Stall=1, PC and IF/ID SHALL hold.
REQ-023 The halt condition is RUN, i_Enable=1, i_Flush=0, i_Stall=0 and i_Instruccion==HALT_WORD; when it holds, the FSM SHALL move to HALT.
REQ-024 On the halt-condition cycle, the PC SHALL hold at the halt address, and IF/ID SHALL capture HALT_WORD with Valid=1.
REQ-025 In HALT with i_Enable=1 and i_Flush=0, the PC SHALL hold and IF/ID SHALL load NOP with Valid=0 (bubbles), regardless of i_Stall.
REQ-026 In HALT with i_Enable=1 and i_Flush=1, the FSM SHALL return to RUN and the PC SHALL load i_MuxPC; this covers a halt fetched on a mispredicted path.
REQ-027 o_Halt SHALL equal (state==HALT) and is registered.
REQ-028 o_PC4 SHALL equal o_PC+4 modulo 2^NBITS, so 0xFFFFFFFC wraps to 0x00000000.
REQ-029 o_CycleCount SHALL increment by 1 on each cycle with i_Enable=1 and state RUN, including stalled cycles.
REQ-030 o_CycleCount SHALL saturate at 0xFFFFFFFF and hold in HALT.
REQ-031 The block SHALL introduce no combinational path from i_MuxPC to any output.

Reset
REQ-032 When i_rst_n=0 at a rising edge, the block SHALL set PC=0, IF/ID Instr=0, PC4=0, Valid=0, state=RUN, o_Halt=0 and o_CycleCount=0.
REQ-033 Reset SHALL override i_Enable, i_Stall and i_Flush, including mid-stall and in HALT.
REQ-034 The first fetch SHALL occur at address 0 on the first enabled cycle after reset deassertion.

Structure
REQ-035 A shared package SHALL hold NBITS, HALT_WORD, NOP_WORD (0) and the RUN/HALT state encoding.
REQ-036 The IF/ID pipeline register SHALL be a sub-module named ifid_reg, with load, flush and hold controls.
REQ-037 The PC register, the FSM and the counter SHALL live in pc_if_stage.

Verification
REQ-038 Reset, then 3 enabled cycles with no stall, memory returning 0x20010005 -> o_PC 0 → 4 → 8 → 12, o_IFID_PC4 = 4, 8, 12, Valid=1, o_CycleCount=3.
REQ-039 i_Stall=1 for 2 cycles at PC=8 -> o_PC stays 8, IF/ID unchanged, o_CycleCount +2.
REQ-040 i_Stall=1 and i_Flush=1 with i_MuxPC=0x40 -> next o_PC=0x40, o_IFID_Instr=0, Valid=0.
REQ-041 i_Instruccion=0xFFFFFFFF at PC=0x10 -> o_Halt=1, o_PC stays 0x10, IF/ID holds HALT_WORD, then NOP with Valid=0, counter frozen.
REQ-042 In HALT, i_Flush=1 with i_MuxPC=0x80 -> o_Halt=0, o_PC=0x80. Separately, i_Enable=0 for 5 cycles -> no state change. Separately, i_rst_n=0 in HALT -> all reset values.

Source files
------------

// File: rtl/pc_if_stage_pkg.sv
// Shared constants and FSM encoding for the PC / instruction-fetch stage.
package pc_if_stage_pkg;

  localparam int unsigned NBITS     = 32;
  localparam int unsigned CNT_W     = 32;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

endpackage

// File: rtl/pc_if_stage_ifid_reg.sv
// IF/ID pipeline register: flush (bubble) beats load, otherwise holds.
module ifid_reg #(
  parameter int unsigned NBITS = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_flush,
  input  logic [NBITS-1:0] i_instr,
  input  logic [NBITS-1:0] i_pc4,
  output logic [NBITS-1:0] o_instr,
  output logic [NBITS-1:0] o_pc4,
  output logic             o_valid
);
  import pc_if_stage_pkg::*;

  logic [NBITS-1:0] instr_q, instr_d;
  logic [NBITS-1:0] pc4_q, pc4_d;
  logic             valid_q, valid_d;

  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (i_flush) begin
      instr_d = NBITS'(NOP_WORD);
      pc4_d   = '0;
      valid_d = 1'b0;
    end else if (i_load) begin
      instr_d = i_instr;
      pc4_d   = i_pc4;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      instr_q <= NBITS'(NOP_WORD);
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign o_instr = instr_q;
  assign o_pc4   = pc4_q;
  assign o_valid = valid_q;

endmodule

// File: rtl/pc_if_stage.sv
// Fetch stage: PC register, RUN/HALT FSM, RUN-cycle counter and IF/ID register.
module pc_if_stage #(
  parameter int unsigned      NBITS     = pc_if_stage_pkg::NBITS,
  parameter logic [NBITS-1:0] HALT_WORD = NBITS'(pc_if_stage_pkg::HALT_WORD)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_Enable,
  input  logic             i_Stall,
  input  logic             i_Flush,
  input  logic [NBITS-1:0] i_MuxPC,
  input  logic [NBITS-1:0] i_Instruccion,
  output logic [NBITS-1:0] o_PC,
  output logic [NBITS-1:0] o_PC4,
  output logic [NBITS-1:0] o_IFID_Instr,
  output logic [NBITS-1:0] o_IFID_PC4,
  output logic             o_IFID_Valid,
  output logic             o_Halt,
  output logic [31:0]      o_CycleCount
);
  import pc_if_stage_pkg::*;

  state_e           state_q, state_d;
  logic [NBITS-1:0] pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halt_q, halt_d;
  logic             ifid_load, ifid_flush;
  logic [NBITS-1:0] pc4;

  assign pc4 = pc_q + NBITS'(4);

  // Next-state: flush wins, HALT emits bubbles, a fetched HALT_WORD parks the PC.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    if (i_Enable) begin
      if (state_q == ST_RUN && cnt_q != {CNT_W{1'b1}})
        cnt_d = cnt_q + CNT_W'(1);
      if (i_Flush) begin
        ifid_flush = 1'b1;
        pc_d       = i_MuxPC;
        state_d    = ST_RUN;
      end else if (state_q == ST_HALT) begin
        ifid_flush = 1'b1;
      end else if (!i_Stall) begin
        ifid_load = 1'b1;
        if (i_Instruccion == HALT_WORD) state_d = ST_HALT;
        else                            pc_d    = i_MuxPC;
      end
    end
    halt_d = (state_d == ST_HALT);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
      cnt_q   <= '0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      halt_q  <= halt_d;
    end
  end

  ifid_reg #(.NBITS(NBITS)) u_ifid (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (ifid_load),
    .i_flush (ifid_flush),
    .i_instr (i_Instruccion),
    .i_pc4   (pc4),
    .o_instr (o_IFID_Instr),
    .o_pc4   (o_IFID_PC4),
    .o_valid (o_IFID_Valid)
  );

  assign o_PC         = pc_q;
  assign o_PC4        = pc4;
  assign o_Halt       = halt_q;
  assign o_CycleCount = 32'(cnt_q);

endmodule

// File: tb/tb_pc_if_stage.sv
// Scoreboard bench for pc_if_stage: directed scenarios then random traffic vs a reference model.
module tb_pc_if_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [31:0] mux_pc = '0, instr = '0;
  logic [31:0] pc, pc4, ifid_instr, ifid_pc4, cyc;
  logic        ifid_valid, halt;

  pc_if_stage dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_Enable(en), .i_Stall(stall), .i_Flush(flush),
    .i_MuxPC(mux_pc), .i_Instruccion(instr),
    .o_PC(pc), .o_PC4(pc4), .o_IFID_Instr(ifid_instr), .o_IFID_PC4(ifid_pc4),
    .o_IFID_Valid(ifid_valid), .o_Halt(halt), .o_CycleCount(cyc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic [31:0] ifpc4;
    logic        valid;
    logic        halt;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // Reference model state
  longint unsigned m_pc, m_instr, m_ifpc4, m_cnt;
  bit              m_valid, m_halted;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are compared one time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pc", pc, e.pc);
      chk("pc4", pc4, e.pc4);
      chk("ifid_instr", ifid_instr, e.instr);
      chk("ifid_pc4", ifid_pc4, e.ifpc4);
      chk("ifid_valid", 32'(ifid_valid), 32'(e.valid));
      chk("halt", 32'(halt), 32'(e.halt));
      chk("cycle_count", cyc, e.cnt);
    end
  end

  // Drive one cycle of inputs and push the model's post-edge view.
  task automatic step(input bit r, input bit e, input bit s, input bit f,
                      input logic [31:0] mpc, input logic [31:0] ins);
    exp_t x;
    @(negedge clk);
    rst_n = r; en = e; stall = s; flush = f; mux_pc = mpc; instr = ins;
    if (!r) begin
      m_pc = 0; m_instr = 0; m_ifpc4 = 0; m_valid = 0; m_halted = 0; m_cnt = 0;
    end else if (e) begin
      if (!m_halted && m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (f) begin
        m_instr = 0; m_ifpc4 = 0; m_valid = 0; m_halted = 0; m_pc = 64'(mpc);
      end else if (m_halted) begin
        m_instr = 0; m_ifpc4 = 0; m_valid = 0;
      end else if (!s) begin
        m_instr = 64'(ins); m_ifpc4 = (m_pc + 4) % 64'h1_0000_0000; m_valid = 1;
        if (ins == 32'hFFFF_FFFF) m_halted = 1;
        else m_pc = 64'(mpc);
      end
    end
    x.pc    = 32'(m_pc);
    x.pc4   = 32'((m_pc + 4) % 64'h1_0000_0000);
    x.instr = 32'(m_instr);
    x.ifpc4 = 32'(m_ifpc4);
    x.valid = m_valid;
    x.halt  = m_halted;
    x.cnt   = 32'(m_cnt);
    q.push_back(x);
  endtask

  function automatic logic [31:0] nxt();
    return 32'((m_pc + 4) % 64'h1_0000_0000);
  endfunction

  localparam logic [31:0] ADDI = 32'h2001_0005;
  localparam logic [31:0] HW   = 32'hFFFF_FFFF;

  initial begin
    m_pc = 0; m_instr = 0; m_ifpc4 = 0; m_valid = 0; m_halted = 0; m_cnt = 0;
    step(0, 1, 1, 1, 32'h1234, ADDI);
    step(0, 0, 0, 0, 32'h0, ADDI);
    // Straight-line fetch from address 0
    repeat (2) step(1, 1, 0, 0, nxt(), ADDI);
    repeat (2) step(1, 1, 1, 0, 32'hDEAD_0000, ADDI);
    step(1, 1, 0, 0, nxt(), ADDI);
    // Flush beats stall
    step(1, 1, 1, 1, 32'h40, ADDI);
    step(1, 1, 0, 1, 32'h10, ADDI);
    // Halt fetched at 0x10, then bubbles regardless of stall
    step(1, 1, 0, 0, 32'h14, HW);
    step(1, 1, 0, 0, 32'h14, ADDI);
    step(1, 1, 1, 0, 32'h14, ADDI);
    repeat (5) step(1, 0, $urandom_range(1), $urandom_range(1), $urandom, HW);
    step(1, 1, 0, 1, 32'h80, ADDI);
    step(1, 1, 0, 0, nxt(), ADDI);
    step(1, 1, 0, 0, nxt(), HW);
    step(1, 1, 1, 1, 32'h0, ADDI);
    step(1, 1, 0, 0, nxt(), HW);
    step(0, 1, 1, 1, 32'h44, HW);
    step(1, 1, 0, 0, nxt(), ADDI);
    // PC+4 wraparound at the top of the address space
    step(1, 1, 0, 1, 32'hFFFF_FFFC, ADDI);
    step(1, 1, 0, 0, nxt(), ADDI);
    // Random traffic
    for (int i = 0; i < 600; i++) begin
      bit r, e, s, f;
      logic [31:0] mpc, ins;
      r   = ($urandom_range(99) != 0);
      e   = ($urandom_range(7) != 0);
      s   = ($urandom_range(3) == 0);
      f   = ($urandom_range(7) == 0);
      mpc = ($urandom_range(3) == 0) ? ($urandom & 32'hFFFF_FFFC) : nxt();
      ins = ($urandom_range(15) == 0) ? HW : $urandom;
      step(r, e, s, f, mpc, ins);
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
